// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the SRAM access sequencer:
//   - sram_state_e : sequencer states
//   - cnt_width()  : width of the wait-state down-counter for a given WAIT_CYCLES
//   - dw_ok() / wait_ok() : parameter legality checks used at elaboration
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } sram_state_e;

  // The counter is loaded with WAIT_CYCLES-1, so it needs clog2(WAIT_CYCLES)
  // bits, but never fewer than one.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
  endfunction

  function automatic bit dw_ok(input int data_w);
    return (data_w >= 8) && (data_w % 8 == 0);
  endfunction

  function automatic bit wait_ok(input int wait_cycles);
    return wait_cycles >= 1;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer
// Loadable down-counter that times the strobe-active window of an access.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : load load_val_i (has priority over en_i)
//   en_i           : decrement by one while not already zero
//   load_val_i     : value to load
//   zero_o         : counter currently equals zero
module sram_wait_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
// Sequences single-word read/write requests onto an asynchronous SRAM with
// WAIT_CYCLES strobe-active cycles, per-byte write enables and a one-cycle
// completion pulse. All SRAM-side outputs are registered.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN -- inserts one idle TURN
// cycle before a write that directly follows a completed read.
// Ports:
//   Clk, Reset                  : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_we/addr/wdata/be        : request attributes (be ignored on reads)
//   resp_valid/resp_rdata       : completion pulse, last read data (held)
//   ADDR, Data_to_SRAM, Data_oe : address, write data, tristate enable
//   Data_from_SRAM              : read data from the tristate buffer
//   Mem_CE/OE/WE, Mem_BE        : active-low SRAM strobes and byte lanes
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [ADDR_W-1:0]   ADDR,
  output logic [DATA_W-1:0]   Data_to_SRAM,
  input  logic [DATA_W-1:0]   Data_from_SRAM,
  output logic                Data_oe,
  output logic                Mem_CE,
  output logic                Mem_OE,
  output logic                Mem_WE,
  output logic [DATA_W/8-1:0] Mem_BE
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  if (!dw_ok(DATA_W)) begin : g_bad_data_w
    $error("sram_access_ctrl: DATA_W must be a positive multiple of 8");
  end
  if (!wait_ok(WAIT_CYCLES)) begin : g_bad_wait
    $error("sram_access_ctrl: WAIT_CYCLES must be at least 1");
  end

  sram_state_e       state_q;
  logic              ready_q, resp_valid_q, we_q;
  logic              doe_q, ce_q, oe_q, mwe_q;
  logic [BE_W-1:0]   be_q, mbe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              tmr_zero, go_turn;

  // SETUP strobes come straight from the request when entering from IDLE,
  // and from the latched copy when entering from TURN.
  logic              setup_we;
  logic [BE_W-1:0]   setup_be;
  assign setup_we = (state_q == ST_IDLE) ? req_we : we_q;
  assign setup_be = (state_q == ST_IDLE) ? req_be : be_q;

  sram_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (state_q == ST_SETUP),
    .en_i       (state_q == ST_ACCESS),
    .load_val_i (CNT_W'(WAIT_CYCLES - 1)),
    .zero_o     (tmr_zero)
  );

`ifdef SRAM_CTRL_TURNAROUND_EN
  logic last_was_read_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_was_read_q <= 1'b0;
    end else if (state_q == ST_ACCESS && tmr_zero) begin
      last_was_read_q <= ~we_q;
    end
  end
  assign go_turn = req_we & last_was_read_q;
`else
  assign go_turn = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      doe_q        <= 1'b0;
      ce_q         <= 1'b1;
      oe_q         <= 1'b1;
      mwe_q        <= 1'b1;
      mbe_q        <= '1;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            be_q    <= req_be;
            ready_q <= 1'b0;
            if (go_turn) begin
              state_q <= ST_TURN;
            end else begin
              state_q <= ST_SETUP;
              ce_q    <= 1'b0;
              oe_q    <= setup_we;
              doe_q   <= setup_we;
              mbe_q   <= setup_we ? ~setup_be : '0;
            end
          end
        end
`ifdef SRAM_CTRL_TURNAROUND_EN
        ST_TURN: begin
          state_q <= ST_SETUP;
          ce_q    <= 1'b0;
          oe_q    <= setup_we;
          doe_q   <= setup_we;
          mbe_q   <= setup_we ? ~setup_be : '0;
        end
`endif
        ST_SETUP: begin
          state_q <= ST_ACCESS;
          mwe_q   <= ~we_q;
        end
        ST_ACCESS: begin
          if (tmr_zero) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            mwe_q        <= 1'b1;
            oe_q         <= 1'b1;
            // A write holds CE, lanes, data and address through DONE.
            if (!we_q) begin
              rdata_q <= Data_from_SRAM;
              ce_q    <= 1'b1;
              mbe_q   <= '1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          ce_q    <= 1'b1;
          oe_q    <= 1'b1;
          mwe_q   <= 1'b1;
          doe_q   <= 1'b0;
          mbe_q   <= '1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = rdata_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_oe      = doe_q;
  assign Mem_CE       = ce_q;
  assign Mem_OE       = oe_q;
  assign Mem_WE       = mwe_q;
  assign Mem_BE       = mbe_q;

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Parametrised SRAM access sequencer for the SLC-3 memory path: accepts single-word read/write requests from the CPU control side, sequences the asynchronous SRAM strobes with configurable wait states and per-byte write enables, and returns read data with a one-cycle response pulse. It sits between the CPU state controller/MDR and the SRAM tristate buffer, replacing hard-wired per-state strobe generation.

## Interface
- DATA_W, 16: data width in bits; multiple of 8, at least 8.
- ADDR_W, 20: SRAM address width.
- WAIT_CYCLES, 2: strobe-active cycles per access; at least 1.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- resp_valid  out  1  one-cycle pulse when an access completes, for reads and writes.
- resp_rdata  out  DATA_W  read data; holds until the next read completes.
- ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data to the tristate buffer.
- Data_from_SRAM  in  DATA_W  read data from the tristate buffer.
- Data_oe  out  1  tristate output enable; drive the bus.
- Mem_CE, Mem_OE, Mem_WE  out  1 each  active-low chip, output and write enables.
- Mem_BE  out  DATA_W/8  active-low byte-lane enables. Bit 1 is UB and bit 0 is LB at DATA_W=16.

## Operation
- FSM states: IDLE, TURN, SETUP, ACCESS, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, wdata, we and be. Next state is SETUP, or TURN under the condition given in Configuration.
- TURN: one idle cycle with all strobes inactive. Next state is SETUP.
- SETUP: ADDR drives the latched address and Mem_CE=0.
  - Read: Mem_OE=0 and Mem_BE=all 0.
  - Write: Mem_OE=1, Data_oe=1 and Mem_BE=~be. Mem_WE stays 1.
  - Wait counter loads WAIT_CYCLES-1. Next state is ACCESS.
- ACCESS: same strobes as SETUP; a write additionally sets Mem_WE=0. The counter decrements each cycle. When the counter is 0:
  - A read captures Data_from_SRAM into resp_rdata at this edge.
  - Next state is DONE.
- DONE: resp_valid=1 and Mem_WE=1.
  - A write keeps Data_oe=1, Mem_CE=0 and the address stable as hold time.
  - Mem_OE=1 for both operation types.
  - Next state is IDLE.
- A write with req_be=0 still runs the full sequence with Mem_BE all 1 and produces resp_valid.
- req_ready=0 in every state except IDLE. Requests not accepted are ignored; req_* must be held by the requester until accepted.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, ADDR=0, Data_to_SRAM=0, Data_oe=0, Mem_CE=Mem_OE=Mem_WE=1, Mem_BE=all 1, last_was_read=0.
- Reset during any state abandons the access on the next edge. No resp_valid is produced and all strobes go inactive in the same cycle.

## Timing
- The acceptance edge is cycle 0. SETUP is cycle 1. ACCESS is cycles 2..WAIT_CYCLES+1. DONE is cycle WAIT_CYCLES+2. IDLE with req_ready=1 is cycle WAIT_CYCLES+3.
- Latency from acceptance to resp_valid is WAIT_CYCLES+2 cycles. With TURN inserted it is WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles; there is no back-to-back acceptance in DONE.
- All outputs are registered; there are no combinational paths from req_* to the SRAM pins.
- Mem_WE is low for exactly WAIT_CYCLES cycles per write. Address and data are stable one cycle before and one cycle after the Mem_WE low window.

## Configuration
- SRAM_CTRL_TURNAROUND_EN defined: a flag last_was_read is set on every completed read and cleared on every completed write.
  - An accepted write with last_was_read=1 goes IDLE→TURN→SETUP.
  - Reads, and writes following writes, go straight to SETUP.
- SRAM_CTRL_TURNAROUND_EN undefined: the TURN state and last_was_read are not compiled. Latency is always WAIT_CYCLES+2.

## Structure
- Package sram_ctrl_pkg contains:
  - the state enum typedef;
  - a clog2-based counter-width constant function;
  - elaboration checks: DATA_W%8==0 and WAIT_CYCLES>=1.
- Sub-module sram_wait_timer: a loadable down-counter of width derived from WAIT_CYCLES, with load, enable and a zero flag.

## Test plan
- Reset then read at 0x00042, WAIT_CYCLES=2, SRAM model returns 0xBEEF:
  - Mem_OE=0 in cycles 1–3.
  - resp_valid at cycle 4 with resp_rdata=0xBEEF.
  - req_ready returns at cycle 5.
- Write 0x1234 to 0x00010 with be=2'b01:
  - Mem_BE=2'b10 in cycles 1–4.
  - Mem_WE=0 in cycles 2–3 only.
  - Data_oe=1 in cycles 1–4.
  - Model shows low byte 0x34 written and upper byte unchanged.
- Read followed immediately by a write:
  - Macro defined: the write's resp_valid arrives 1 cycle later than with the macro undefined.
  - Write followed by write: no TURN in either build.
- Reset asserted in cycle 2 of a write:
  - Next cycle all strobes are high and Data_oe=0.
  - No resp_valid; req_ready=1.
  - Model memory is unchanged.
- WAIT_CYCLES=1, DATA_W=32: a read of 0xDEADBEEF gives resp_valid at cycle 3, with Mem_BE=4'b0000 during the access.
